sample_rate_ctrl: RTL and testbench

Controller for the receive-path decimating sampler that sits between the baseband control logic and the I/Q sample stage.
- Accepts backscatter-link speed requests over a req/ack handshake.
- Drives the sampler's speed code.
- Blanks output during a programmable filter-settling window after any speed change.
- Generates the one-cycle sample strobe at the selected decimation ratio and counts delivered samples.

---
 rtl/sample_rate_ctrl.sv | 150 +++++++++++++++
 tb/tb_sample_rate_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_rate_ctrl.sv
// Receive-path sampler controller: speed-code handshake, post-change settle blanking,
// decimated sample strobe and delivered-sample counter. Define SAMPLE_CTRL_CNT_SAT_EN to saturate the counter.
module sample_rate_ctrl #(
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 cfg_req_i,
    input  logic [2:0]           cfg_speed_i,
    output logic                 cfg_ack_o,
    output logic [2:0]           speed_o,
    output logic                 sample_en_o,
    output logic                 settled_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] sample_cnt_o
);

    // state  | meaning
    // IDLE   | sampler stopped, speed changes still accepted
    // SETTLE | filter settling after enable or speed change, output blanked
    // RUN    | strobing at the selected decimation ratio

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [3:0]           div_q, div_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]           speed_q;
    logic                 ack_q;
    logic                 req_held_q;
    logic                 accept;
    logic                 strobe;
    logic [3:0]           div_last;

    // Divider terminal value is N-1 for the active speed code.
    always_comb begin
        div_last = 4'd9;
        case (speed_q)
            3'b000:  div_last = 4'd9;
            3'b001:  div_last = 4'd4;
            3'b010:  div_last = 4'd3;
            3'b011:  div_last = 4'd1;
            3'b100:  div_last = 4'd4;
            3'b101:  div_last = 4'd2;
            3'b110:  div_last = 4'd1;
            3'b111:  div_last = 4'd0;
            default: div_last = 4'd9;
        endcase
    end

    // A request still held from a previous accept is not taken again until dropped.
    assign accept = cfg_req_i && !ack_q && !req_held_q;
    assign strobe = (state_q == ST_RUN) && !accept && (div_q == div_last);

`ifdef SAMPLE_CTRL_CNT_SAT_EN
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
`else
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);
`endif

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        if (strobe) begin
            cnt_d = cnt_inc;
        end
        if (!enable_i) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            div_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LOAD;
                    div_d    = '0;
                end
                ST_SETTLE: begin
                    if (accept) begin
                        settle_d = SETTLE_LOAD;
                    end else if (settle_q == '0) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        settle_d = settle_q - SW'(1);
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                        div_d    = '0;
                    end else if (div_q == div_last) begin
                        div_d = '0;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    settle_d = '0;
                    div_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            speed_q    <= 3'b000;
            ack_q      <= 1'b0;
            req_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            ack_q      <= accept;
            req_held_q <= cfg_req_i && (accept || req_held_q);
            if (accept) begin
                speed_q <= cfg_speed_i;
            end
        end
    end

    assign cfg_ack_o    = ack_q;
    assign speed_o      = speed_q;
    assign sample_en_o  = strobe;
    assign settled_o    = (state_q == ST_RUN);
    assign busy_o       = (state_q == ST_SETTLE);
    assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_sample_rate_ctrl.sv
// Bench for sample_rate_ctrl: directed scenarios plus randomized traffic checked against
// a cycle-level behavioural model (mode, cycles left to settle, cycles since RUN entry).
module tb_sample_rate_ctrl;

    localparam int TB_SETTLE = 64;
    localparam int TB_CNT_W  = 4;
    localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic                enable_i = 1'b0;
    logic                cfg_req_i = 1'b0;
    logic [2:0]          cfg_speed_i = 3'b000;
    logic                cfg_ack_o;
    logic [2:0]          speed_o;
    logic                sample_en_o;
    logic                settled_o;
    logic                busy_o;
    logic [TB_CNT_W-1:0] sample_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    sample_rate_ctrl #(.SETTLE_CYCLES(TB_SETTLE), .CNT_WIDTH(TB_CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .cfg_req_i   (cfg_req_i),
        .cfg_speed_i (cfg_speed_i),
        .cfg_ack_o   (cfg_ack_o),
        .speed_o     (speed_o),
        .sample_en_o (sample_en_o),
        .settled_o   (settled_o),
        .busy_o      (busy_o),
        .sample_cnt_o(sample_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // behavioural model: md 0=idle 1=settle 2=run
    int       md, m_left, m_phase, m_cnt;
    logic [2:0] m_speed;
    logic     m_ack, m_held, m_acc;

    // snapshot of DUT outputs and model expectations for the current cycle
    logic s_ack, s_sample, s_settled, s_busy;
    logic [2:0] s_speed;
    logic [TB_CNT_W-1:0] s_cnt;
    logic e_ack, e_sample, e_settled, e_busy;
    logic [2:0] e_speed;
    logic [TB_CNT_W-1:0] e_cnt;

    function automatic int div_n(input logic [2:0] s);
        case (s)
            3'b000: return 10;
            3'b001: return 5;
            3'b010: return 4;
            3'b011: return 2;
            3'b100: return 5;
            3'b101: return 3;
            3'b110: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        md = 0; m_left = 0; m_phase = 0; m_cnt = 0;
        m_speed = 3'b000; m_ack = 1'b0; m_held = 1'b0;
    endtask

    // Sample outputs at negedge, advance the model over the following posedge.
    task automatic clk_step();
        @(negedge clk_i);
        s_ack = cfg_ack_o; s_speed = speed_o; s_sample = sample_en_o;
        s_settled = settled_o; s_busy = busy_o; s_cnt = sample_cnt_o;
        m_acc     = cfg_req_i && !m_ack && !m_held;
        e_ack     = m_ack;
        e_speed   = m_speed;
        e_busy    = (md == 1);
        e_settled = (md == 2);
        e_cnt     = TB_CNT_W'(m_cnt);
        e_sample  = (md == 2) && !m_acc && (((m_phase + 1) % div_n(m_speed)) == 0);
        @(posedge clk_i);
        if (e_sample) begin
`ifdef SAMPLE_CTRL_CNT_SAT_EN
            m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
`else
            m_cnt = (m_cnt + 1) % (CNT_MAX + 1);
`endif
        end
        m_held = cfg_req_i && (m_acc || m_held);
        m_ack  = m_acc;
        if (m_acc) m_speed = cfg_speed_i;
        if (!enable_i) begin
            md = 0; m_left = 0; m_phase = 0;
        end else if (md == 0) begin
            md = 1; m_left = TB_SETTLE;
        end else if (md == 1) begin
            if (m_acc) m_left = TB_SETTLE;
            else if (m_left == 1) begin md = 2; m_phase = 0; m_cnt = 0; end
            else m_left = m_left - 1;
        end else begin
            if (m_acc) begin md = 1; m_left = TB_SETTLE; end
            else m_phase = m_phase + 1;
        end
        #1;
    endtask

    // Steps until settled_o is seen; counts busy cycles on the way.
    task automatic run_until_settled(output bit found, output int busy_n, input int start_busy);
        found = 0;
        busy_n = start_busy;
        for (int i = 0; i < 300 && !found; i++) begin
            clk_step();
            if (s_busy) busy_n++;
            if (s_settled) found = 1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b0; cfg_req_i = 1'b0; cfg_speed_i = 3'b000;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if ({cfg_ack_o, speed_o, sample_en_o, settled_o, busy_o} !== 7'b0 || sample_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ack=%b spd=%b smp=%b set=%b busy=%b cnt=%0d, expected all 0",
                     cfg_ack_o, speed_o, sample_en_o, settled_o, busy_o, sample_cnt_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_settle_run();
        bit found; int busy_n; int first_idx; int n_str;
        enable_i = 1'b1;
        run_until_settled(found, busy_n, 0);
        vectors++;
        if (!found) begin miscompares++; $display("FAIL settle_timeout: settled_o never rose, expected within 300 cycles"); end
        vectors++;
        if (busy_n != 64) begin miscompares++; $display("FAIL settle_len: got %0d busy cycles, expected 64", busy_n); end
        first_idx = -1; n_str = 0;
        for (int idx = 0; idx < 50; idx++) begin
            if (idx > 0) clk_step();
            if (s_sample) begin n_str++; if (first_idx < 0) first_idx = idx; end
        end
        vectors++;
        if (first_idx != 9) begin miscompares++; $display("FAIL first_strobe: got RUN cycle %0d, expected 9", first_idx); end
        vectors++;
        if (n_str != 5) begin miscompares++; $display("FAIL strobe_count_n10: got %0d, expected 5", n_str); end
        clk_step();
        vectors++;
        if (s_cnt !== 4'd5) begin miscompares++; $display("FAIL sample_cnt_50: got %0d, expected 5", s_cnt); end
    endtask

    task automatic test_speed_change();
        bit found; int busy_n;
        cfg_req_i = 1'b1; cfg_speed_i = 3'b111;
        clk_step();
        vectors++;
        if (s_ack !== 1'b0 || s_sample !== 1'b0) begin miscompares++; $display("FAIL accept_cycle: got ack=%b smp=%b, expected 0 0", s_ack, s_sample); end
        cfg_req_i = 1'b0;
        clk_step();
        vectors++;
        if (s_ack !== 1'b1 || s_speed !== 3'b111) begin miscompares++; $display("FAIL ack_speed: got ack=%b spd=%b, expected 1 111", s_ack, s_speed); end
        run_until_settled(found, busy_n, s_busy ? 1 : 0);
        vectors++;
        if (!found || busy_n != 64) begin miscompares++; $display("FAIL resettle_len: got %0d busy (found=%0d), expected 64", busy_n, found); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) clk_step();
            vectors++;
            if (s_sample !== 1'b1 || s_cnt !== TB_CNT_W'(k)) begin
                miscompares++;
                $display("FAIL n1_strobe[%0d]: got smp=%b cnt=%0d, expected 1 %0d", k, s_sample, s_cnt, k);
            end
        end
    endtask

    task automatic test_settle_restart();
        bit found; int busy_n; int first_idx; int n_str;
        cfg_req_i = 1'b1; cfg_speed_i = 3'b010;
        clk_step();
        cfg_req_i = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 100 && busy_n < 54; i++) begin
            clk_step();
            if (s_busy) busy_n++;
        end
        cfg_req_i = 1'b1; cfg_speed_i = 3'b101;
        clk_step();
        cfg_req_i = 1'b0;
        clk_step();
        vectors++;
        if (s_ack !== 1'b1 || s_speed !== 3'b101 || s_busy !== 1'b1) begin
            miscompares++; $display("FAIL restart_ack: got ack=%b spd=%b busy=%b, expected 1 101 1", s_ack, s_speed, s_busy);
        end
        run_until_settled(found, busy_n, s_busy ? 1 : 0);
        vectors++;
        if (!found || busy_n != 64) begin miscompares++; $display("FAIL restart_len: got %0d busy from ack, expected 64", busy_n); end
        first_idx = -1; n_str = 0;
        for (int idx = 0; idx < 9; idx++) begin
            if (idx > 0) clk_step();
            if (s_sample) begin n_str++; if (first_idx < 0) first_idx = idx; end
        end
        vectors++;
        if (first_idx != 2 || n_str != 3) begin
            miscompares++; $display("FAIL period3: got first=%0d count=%0d, expected 2 3", first_idx, n_str);
        end
    endtask

    task automatic test_hold_req();
        int acks; int ack_idx;
        acks = 0; ack_idx = -1;
        cfg_speed_i = 3'b110;
        for (int i = 0; i < 7; i++) begin
            cfg_req_i = (i < 5);
            clk_step();
            if (s_ack) begin acks++; if (ack_idx < 0) ack_idx = i; end
        end
        vectors++;
        if (acks != 1 || ack_idx != 1) begin miscompares++; $display("FAIL held_req: got %0d acks first at %0d, expected 1 at 1", acks, ack_idx); end
        cfg_req_i = 1'b1; cfg_speed_i = 3'b001;
        clk_step();
        cfg_req_i = 1'b0;
        clk_step();
        vectors++;
        if (s_ack !== 1'b1 || s_speed !== 3'b001) begin miscompares++; $display("FAIL reassert_ack: got ack=%b spd=%b, expected 1 001", s_ack, s_speed); end
    endtask

    task automatic test_disable_with_req();
        bit found; int busy_n; int n_str; logic [TB_CNT_W-1:0] held_cnt;
        run_until_settled(found, busy_n, 0);
        vectors++;
        if (!found) begin miscompares++; $display("FAIL disable_setup: settled_o never rose"); end
        repeat (7) clk_step();
        enable_i = 1'b0; cfg_req_i = 1'b1; cfg_speed_i = 3'b011;
        clk_step();
        cfg_req_i = 1'b0;
        clk_step();
        held_cnt = e_cnt;
        vectors++;
        if (s_ack !== 1'b1 || s_speed !== 3'b011 || s_busy !== 1'b0 || s_settled !== 1'b0 || s_cnt !== e_cnt) begin
            miscompares++;
            $display("FAIL disable_req: got ack=%b spd=%b busy=%b set=%b cnt=%0d, expected 1 011 0 0 %0d",
                     s_ack, s_speed, s_busy, s_settled, s_cnt, e_cnt);
        end
        n_str = 0;
        for (int i = 0; i < 20; i++) begin
            clk_step();
            if (s_sample) n_str++;
        end
        vectors++;
        if (n_str != 0 || s_cnt !== held_cnt) begin
            miscompares++; $display("FAIL idle_quiet: got %0d strobes cnt=%0d, expected 0 strobes cnt=%0d", n_str, s_cnt, held_cnt);
        end
    endtask

    task automatic test_cnt_limit_and_async_reset();
        bit found; int busy_n; logic [TB_CNT_W-1:0] exp_cnt;
        cfg_req_i = 1'b1; cfg_speed_i = 3'b111;
        clk_step();
        cfg_req_i = 1'b0; enable_i = 1'b1;
        run_until_settled(found, busy_n, 0);
        repeat (20) clk_step();
`ifdef SAMPLE_CTRL_CNT_SAT_EN
        exp_cnt = 4'd15;
`else
        exp_cnt = 4'd4;
`endif
        vectors++;
        if (!found || s_cnt !== exp_cnt) begin
            miscompares++; $display("FAIL cnt_limit: got %0d (found=%0d), expected %0d", s_cnt, found, exp_cnt);
        end
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({cfg_ack_o, speed_o, sample_en_o, settled_o, busy_o} !== 7'b0 || sample_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got ack=%b spd=%b smp=%b set=%b busy=%b cnt=%0d, expected all 0",
                     cfg_ack_o, speed_o, sample_en_o, settled_o, busy_o, sample_cnt_o);
        end
        model_reset();
        enable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            enable_i = ($urandom_range(0, 99) < 97);
            if (cfg_req_i) cfg_req_i = ($urandom_range(0, 1) == 1);
            else cfg_req_i = ($urandom_range(0, 99) < 4);
            cfg_speed_i = 3'($urandom_range(0, 7));
            clk_step();
            vectors++;
            if (s_ack !== e_ack || s_speed !== e_speed || s_sample !== e_sample ||
                s_settled !== e_settled || s_busy !== e_busy || s_cnt !== e_cnt) begin
                miscompares++;
                $display("FAIL random[%0d]: got ack=%b spd=%b smp=%b set=%b busy=%b cnt=%0d, expected %b %b %b %b %b %0d",
                         i, s_ack, s_speed, s_sample, s_settled, s_busy, s_cnt,
                         e_ack, e_speed, e_sample, e_settled, e_busy, e_cnt);
            end
        end
        cfg_req_i = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_settle_run();
        test_speed_change();
        test_settle_restart();
        test_hold_req();
        test_disable_with_req();
        test_cnt_limit_and_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
